// File: rtl/complex_magnitude_peak_pkg.sv
// Shared definitions for the complex magnitude / peak detector slice.
//  - MAG_* : run-time approximation mode encodings carried on the mode port
//  - mag_width() : width of the unsigned magnitude estimate for a given sample width
package complex_magnitude_peak_pkg;

  localparam logic [1:0] MAG_ABS_RE    = 2'd0;  // |Re|
  localparam logic [1:0] MAG_L1        = 2'd1;  // max + min
  localparam logic [1:0] MAG_AMBM_HALF = 2'd2;  // max + min/2
  localparam logic [1:0] MAG_AMBM_38   = 2'd3;  // max + min/4 + min/8

  // One extra bit holds max+min of two DW-bit magnitudes without overflow.
  function automatic int mag_width(input int dw);
    return dw + 1;
  endfunction

endpackage

// File: rtl/complex_magnitude_peak_peak_window_tracker.sv
// Windowed peak tracker: counts WINDOW_LEN valid samples, remembers the largest
// one (earliest index on ties) and pulses peakValid for one cycle the cycle after
// the window's last sample, loading peakOut/peakIndex, which then hold.
// Ports:
//  clock, resetN          clock / async active-low reset
//  valid, data            sample stream to track
//  clear                  synchronous window restart; a coincident sample is dropped
//  peakValid              one-cycle window-complete pulse
//  peakOut, peakIndex     peak value and its 0-based position in the window
module peak_window_tracker
  import complex_magnitude_peak_pkg::*;
#(
  parameter int WIDTH       = 19,
  parameter int WINDOW_LEN  = 64,
  parameter int INDEX_WIDTH = 6
) (
  input  logic                   clock,
  input  logic                   resetN,
  input  logic                   valid,
  input  logic [WIDTH-1:0]       data,
  input  logic                   clear,
  output logic                   peakValid,
  output logic [WIDTH-1:0]       peakOut,
  output logic [INDEX_WIDTH-1:0] peakIndex
);

  localparam logic [INDEX_WIDTH-1:0] LAST = INDEX_WIDTH'(WINDOW_LEN - 1);

  logic [INDEX_WIDTH-1:0] cnt;
  logic [WIDTH-1:0]       curMax;
  logic [INDEX_WIDTH-1:0] curIdx;

  logic                   take;
  logic [WIDTH-1:0]       nxtMax;
  logic [INDEX_WIDTH-1:0] nxtIdx;

  // First sample of a window always loads; afterwards only a strictly larger
  // value replaces the held one so ties keep the earliest index.
  always_comb begin
    take   = (cnt == '0) || (data > curMax);
    nxtMax = take ? data : curMax;
    nxtIdx = take ? cnt  : curIdx;
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      cnt       <= '0;
      curMax    <= '0;
      curIdx    <= '0;
      peakValid <= 1'b0;
      peakOut   <= '0;
      peakIndex <= '0;
    end else begin
      peakValid <= 1'b0;
      if (clear) begin
        cnt    <= '0;
        curMax <= '0;
        curIdx <= '0;
      end else if (valid) begin
        if (cnt == LAST) begin
          // last sample takes part in the comparison, then the tracker restarts
          peakValid <= 1'b1;
          peakOut   <= nxtMax;
          peakIndex <= nxtIdx;
          cnt       <= '0;
          curMax    <= '0;
          curIdx    <= '0;
        end else begin
          cnt    <= cnt + 1'b1;
          curMax <= nxtMax;
          curIdx <= nxtIdx;
        end
      end
    end
  end

endmodule

// File: rtl/complex_magnitude_peak.sv
// Pipelined magnitude estimator for complex I/Q samples with four selectable
// approximations, followed by a windowed peak detector.
// Ports:
//  clock, resetN                 clock / async active-low reset
//  dataInValid, dataInRe/Im      signed input sample, qualified by dataInValid
//  mode                          approximation select, travels with its sample
//  windowClear                   synchronous restart of the peak window
//  dataOutValid, dataOut         magnitude estimate, 3 cycles after input; 0 when not valid
//  peakValid, peakOut, peakIndex per-window peak report
module complex_magnitude_peak
  import complex_magnitude_peak_pkg::*;
#(
  parameter int DATA_WIDTH  = 18,
  parameter int WINDOW_LEN  = 64,
  parameter int INDEX_WIDTH = 6
) (
  input  logic                        clock,
  input  logic                        resetN,
  input  logic                        dataInValid,
  input  logic [DATA_WIDTH-1:0]       dataInRe,
  input  logic [DATA_WIDTH-1:0]       dataInIm,
  input  logic [1:0]                  mode,
  input  logic                        windowClear,
  output logic                        dataOutValid,
  output logic [DATA_WIDTH:0]         dataOut,
  output logic                        peakValid,
  output logic [DATA_WIDTH:0]         peakOut,
  output logic [INDEX_WIDTH-1:0]      peakIndex
);

  localparam int OW     = mag_width(DATA_WIDTH);
  localparam int STAGES = 3;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] re;   // |Re|
    logic [DATA_WIDTH-1:0] im;   // |Im|
    logic [1:0]            mode;
  } s1_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] mx;
    logic [DATA_WIDTH-1:0] mn;
    logic [DATA_WIDTH-1:0] re;   // |Re| kept for the |Re|-only mode
    logic [1:0]            mode;
  } s2_t;

  logic [STAGES:1] vld_pipe;
  s1_t             s1, s1_d;
  s2_t             s2, s2_d;
  logic [OW-1:0]   mag;

  // S1: absolute values. Two's-complement negate in DW bits read as unsigned,
  // so the most negative input lands on 2^(DW-1) instead of saturating.
  always_comb begin
    s1_d.re   = dataInRe[DATA_WIDTH-1] ? (-dataInRe) : dataInRe;
    s1_d.im   = dataInIm[DATA_WIDTH-1] ? (-dataInIm) : dataInIm;
    s1_d.mode = mode;
  end

  // S2: sort; on a tie |Re| is taken as max
  always_comb begin
    s2_d.re   = s1.re;
    s2_d.mode = s1.mode;
    if (s1.re >= s1.im) begin
      s2_d.mx = s1.re;
      s2_d.mn = s1.im;
    end else begin
      s2_d.mx = s1.im;
      s2_d.mn = s1.re;
    end
  end

  // S3: approximation; shifts truncate, the extra output bit absorbs the carry
  always_comb begin
    mag = '0;
    case (s2.mode)
      MAG_ABS_RE:    mag = OW'(s2.re);
      MAG_L1:        mag = OW'(s2.mx) + OW'(s2.mn);
      MAG_AMBM_HALF: mag = OW'(s2.mx) + OW'(s2.mn >> 1);
      MAG_AMBM_38:   mag = OW'(s2.mx) + OW'(s2.mn >> 2) + OW'(s2.mn >> 3);
      default:       mag = '0;
    endcase
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      vld_pipe <= '0;
      s1       <= '0;
      s2       <= '0;
      dataOut  <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], dataInValid};
      s1       <= s1_d;
      s2       <= s2_d;
      // output forced to zero on bubbles
      dataOut  <= vld_pipe[STAGES-1] ? mag : '0;
    end
  end

  assign dataOutValid = vld_pipe[STAGES];

  peak_window_tracker #(
    .WIDTH       (OW),
    .WINDOW_LEN  (WINDOW_LEN),
    .INDEX_WIDTH (INDEX_WIDTH)
  ) u_peak (
    .clock     (clock),
    .resetN    (resetN),
    .valid     (dataOutValid),
    .data      (dataOut),
    .clear     (windowClear),
    .peakValid (peakValid),
    .peakOut   (peakOut),
    .peakIndex (peakIndex)
  );

endmodule

// File: tb/tb_complex_magnitude_peak.sv
module tb_complex_magnitude_peak;

  localparam int DW = 18;
  localparam int WL = 4;
  localparam int IW = 2;

  logic          clock = 1'b0;
  logic          resetN;
  logic          dataInValid;
  logic [DW-1:0] dataInRe, dataInIm;
  logic [1:0]    mode;
  logic          windowClear;
  logic          dataOutValid;
  logic [DW:0]   dataOut;
  logic          peakValid;
  logic [DW:0]   peakOut;
  logic [IW-1:0] peakIndex;

  complex_magnitude_peak #(.DATA_WIDTH(DW), .WINDOW_LEN(WL), .INDEX_WIDTH(IW)) dut (
    .clock(clock), .resetN(resetN), .dataInValid(dataInValid),
    .dataInRe(dataInRe), .dataInIm(dataInIm), .mode(mode),
    .windowClear(windowClear), .dataOutValid(dataOutValid), .dataOut(dataOut),
    .peakValid(peakValid), .peakOut(peakOut), .peakIndex(peakIndex)
  );

  always #5 clock = ~clock;

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { bit v; int re; int im; int md; } smp_t;
  smp_t q[$];     // inputs accepted at the last three edges
  int   wq[$];    // magnitudes of the current peak window
  bit   ev, epv;
  int   eo, epo, epi;

  function automatic int mag(input int re, input int im, input int md);
    int a, b, mx, mn;
    a  = (re < 0) ? -re : re;
    b  = (im < 0) ? -im : im;
    mx = (a >= b) ? a : b;
    mn = (a >= b) ? b : a;
    case (md)
      0: return a;
      1: return mx + mn;
      2: return mx + mn / 2;
      default: return mx + mn / 4 + mn / 8;
    endcase
  endfunction

  initial begin
    smp_t s;
    int bi;
    ev = 0; eo = 0; epv = 0; epo = 0; epi = 0;
    forever begin
      @(posedge clock);
      #1;
      if (!resetN) begin
        q.delete(); wq.delete();
        ev = 0; eo = 0; epv = 0; epo = 0; epi = 0;
      end else begin
        // tracker sees the output that was visible before this edge
        epv = 0;
        if (windowClear) wq.delete();
        else if (ev) begin
          wq.push_back(eo);
          if (wq.size() == WL) begin
            bi = 0;
            for (int i = 1; i < WL; i++) if (wq[i] > wq[bi]) bi = i;
            epv = 1; epo = wq[bi]; epi = bi;
            wq.delete();
          end
        end
        s.v = dataInValid; s.re = int'($signed(dataInRe));
        s.im = int'($signed(dataInIm)); s.md = int'(mode);
        q.push_back(s);
        if (q.size() > 3) void'(q.pop_front());
        if (q.size() == 3) begin
          ev = q[0].v;
          eo = q[0].v ? mag(q[0].re, q[0].im, q[0].md) : 0;
        end else begin
          ev = 0; eo = 0;
        end
      end
      chk("dataOutValid", 32'(dataOutValid), 32'(ev));
      chk("dataOut",      32'(dataOut),      32'(eo));
      chk("peakValid",    32'(peakValid),    32'(epv));
      chk("peakOut",      32'(peakOut),      32'(epo));
      chk("peakIndex",    32'(peakIndex),    32'(epi));
    end
  end

  // ---------------- stimulus ----------------
  // Called at posedge+2; returns at the next posedge+2.
  task automatic cyc(input bit v, input int re, input int im, input int md, input bit clr);
    dataInValid = v; dataInRe = DW'(re); dataInIm = DW'(im);
    mode = 2'(md); windowClear = clr;
    @(posedge clock); #2;
  endtask

  task automatic dir(input string tag, input int re, input int im, input int md, input int exp);
    cyc(1, re, im, md, 0);
    cyc(0, 0, 0, 0, 0);
    @(posedge clock); #1;
    chk({tag, "_vld"}, 32'(dataOutValid), 32'd1);
    chk(tag, 32'(dataOut), 32'(exp));
    #1;
  endtask

  task automatic wait_peak(input string tag, input int expo, input int expi);
    int seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clock); #1;
      if (peakValid) begin
        seen++;
        chk({tag, "_out"}, 32'(peakOut), 32'(expo));
        chk({tag, "_idx"}, 32'(peakIndex), 32'(expi));
      end
    end
    chk({tag, "_pulses"}, 32'(seen), 32'd1);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_dov"}, 32'(dataOutValid), 0);
    chk({tag, "_do"},  32'(dataOut), 0);
    chk({tag, "_pv"},  32'(peakValid), 0);
    chk({tag, "_po"},  32'(peakOut), 0);
    chk({tag, "_pi"},  32'(peakIndex), 0);
  endtask

  initial begin
    int re, im;
    resetN = 1'b0; dataInValid = 0; dataInRe = '0; dataInIm = '0;
    mode = '0; windowClear = 0;
    #1;
    chk_zero("reset");
    repeat (3) @(posedge clock);
    #2;
    resetN = 1'b1;

    // modes on Re=-300, Im=400
    dir("mode0", -300, 400, 0, 300);
    dir("mode1", -300, 400, 1, 700);
    dir("mode2", -300, 400, 2, 550);
    dir("mode3", -300, 400, 3, 512);
    // extremes
    dir("ext_neg", -131072, -131072, 1, 262144);
    dir("ext_zero", 0, 0, 3, 0);

    // bubbles 1,0,1,1,0 with a mode change mid-stream
    cyc(1, 10, -20, 1, 0);
    cyc(0, 99, 99, 1, 0);
    cyc(1, -7, 3, 2, 0);
    cyc(1, 100, 100, 3, 0);
    cyc(0, 5, 5, 0, 0);
    repeat (4) cyc(0, 0, 0, 0, 0);

    // peak window 5,9,9,2 from index 0
    cyc(0, 0, 0, 1, 1);
    cyc(1, 5, 0, 1, 0);
    cyc(1, 9, 0, 1, 0);
    cyc(1, 0, -9, 1, 0);
    cyc(1, -2, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);
    wait_peak("peak", 9, 1);

    // partial window discarded by clear, then a full window
    cyc(1, 20, 0, 1, 0);
    cyc(1, 30, 0, 1, 0);
    repeat (4) cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 1);
    cyc(1, 3, 0, 1, 0);
    cyc(1, 8, 0, 1, 0);
    cyc(1, 1, 0, 1, 0);
    cyc(1, 0, 8, 1, 0);
    cyc(0, 0, 0, 1, 0);
    wait_peak("clrpeak", 8, 1);

    // randomized traffic with a mid-stream reset
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        resetN = 1'b0;
        #1;
        chk_zero("midreset");
        #1;
        repeat (2) cyc(1, 1, 1, 1, 0);
        resetN = 1'b1;
      end
      re = ($urandom_range(0, 19) == 0) ? -131072 : int'($urandom_range(0, 262143)) - 131072;
      im = ($urandom_range(0, 19) == 0) ? -131072 : int'($urandom_range(0, 262143)) - 131072;
      if ($urandom_range(0, 9) == 0) im = re;
      cyc($urandom_range(0, 9) < 7, re, im, int'($urandom_range(0, 3)),
          $urandom_range(0, 29) == 0);
    end
    repeat (8) cyc(0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
